csr_exec_unit: RTL and testbench



---
 rtl/csr_exec_unit_pkg.sv | 68 ++++++
 rtl/csr_counter64.sv | 48 ++++
 rtl/csr_exec_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_csr_exec_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/csr_exec_unit_pkg.sv
// Shared definitions for the machine-mode CSR execution unit: operation codes,
// CSR addresses, per-CSR write masks, FSM states and the read-modify-write helpers.
package csr_exec_unit_pkg;

   localparam int CSR_OP_WIDTH = 3;

   localparam logic [2:0] CSR_OP_NA  = 3'd0;
   localparam logic [2:0] CSR_OP_RW  = 3'd1;
   localparam logic [2:0] CSR_OP_RS  = 3'd2;
   localparam logic [2:0] CSR_OP_RC  = 3'd3;
   localparam logic [2:0] CSR_OP_RWI = 3'd5;
   localparam logic [2:0] CSR_OP_RSI = 3'd6;
   localparam logic [2:0] CSR_OP_RCI = 3'd7;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
   localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
   localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
   localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } csr_state_e;

   function automatic logic csr_op_is_imm(input logic [2:0] op);
      return (op == CSR_OP_RWI) || (op == CSR_OP_RSI) || (op == CSR_OP_RCI);
   endfunction

   function automatic logic csr_op_valid(input logic [2:0] op);
      case (op)
         CSR_OP_RW, CSR_OP_RS, CSR_OP_RC,
         CSR_OP_RWI, CSR_OP_RSI, CSR_OP_RCI: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] csr_op_apply(input logic [2:0] op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] src);
      case (op)
         CSR_OP_RW, CSR_OP_RWI: return src;
         CSR_OP_RS, CSR_OP_RSI: return old_val | src;
         CSR_OP_RC, CSR_OP_RCI: return old_val & ~src;
         default:               return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; a write to
// either half suppresses the increment for that cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inc_en_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] count_o
);

   logic [63:0] count_q;
   logic [63:0] count_d;

   // Next count: half writes win over the increment, untouched half holds.
   always_comb begin
      count_d = count_q;
      if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) begin
            count_d[31:0] = wdata_i;
         end else begin
            count_d[31:0] = count_q[31:0];
         end
         if (wr_hi_i) begin
            count_d[63:32] = wdata_i;
         end else begin
            count_d[63:32] = count_q[63:32];
         end
      end else if (inc_en_i) begin
         count_d = count_q + 64'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= 64'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/csr_exec_unit.sv
// Machine-mode CSR file with a three-state read-modify-write sequencer
// (IDLE -> READ -> WRITE) serving one SYSTEM instruction at a time.
module csr_exec_unit #(
   parameter int          CSR_OP_WIDTH = 3,
   parameter logic [31:0] HART_ID      = 32'd0,
   parameter logic [31:0] MISA_VAL     = 32'h4000_1101
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    csr_valid,
   input  logic [CSR_OP_WIDTH-1:0] CSRop,
   input  logic                    CSRwe,
   input  logic                    CSRre,
   input  logic [11:0]             csr_addr,
   input  logic [31:0]             rs1_data,
   input  logic [4:0]              uimm,
   input  logic                    instret_inc,
   output logic [31:0]             csr_rdata,
   output logic                    csr_ready,
   output logic                    csr_illegal,
   output logic                    csr_busy
);
   import csr_exec_unit_pkg::*;

   csr_state_e              state_q, state_d;
   logic [CSR_OP_WIDTH-1:0] op_q, op_d;
   logic                    we_q, we_d, re_q, re_d;
   logic [11:0]             addr_q, addr_d;
   logic [31:0]             src_q, src_d;
   logic [31:0]             new_q, new_d;
   logic                    wen_q, wen_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    ready_q, ready_d, illegal_q, illegal_d, busy_q, busy_d;

   logic [31:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;

   logic [31:0] old_s;
   logic        impl_s, illegal_s, commit_s;
   logic        mcy_wr_lo_s, mcy_wr_hi_s, mir_wr_lo_s, mir_wr_hi_s;
   logic [63:0] mcycle_s, minstret_s;

   csr_counter64 u_mcycle (
      .clk      (clk),
      .resetn   (resetn),
      .inc_en_i (1'b1),
      .wr_lo_i  (mcy_wr_lo_s),
      .wr_hi_i  (mcy_wr_hi_s),
      .wdata_i  (new_q),
      .count_o  (mcycle_s)
   );

   csr_counter64 u_minstret (
      .clk      (clk),
      .resetn   (resetn),
      .inc_en_i (instret_inc),
      .wr_lo_i  (mir_wr_lo_s),
      .wr_hi_i  (mir_wr_hi_s),
      .wdata_i  (new_q),
      .count_o  (minstret_s)
   );

   // Read mux over the latched address; unknown addresses are flagged unimplemented.
   always_comb begin
      old_s  = 32'd0;
      impl_s = 1'b1;
      case (addr_q)
         CSR_MSTATUS:               old_s = mstatus_q | MSTATUS_MPP;
         CSR_MISA:                  old_s = MISA_VAL;
         CSR_MIE:                   old_s = mie_q;
         CSR_MTVEC:                 old_s = mtvec_q;
         CSR_MSCRATCH:              old_s = mscratch_q;
         CSR_MEPC:                  old_s = mepc_q;
         CSR_MCAUSE:                old_s = mcause_q;
         CSR_MTVAL:                 old_s = mtval_q;
         CSR_MCYCLE,   CSR_CYCLE:   old_s = mcycle_s[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:  old_s = mcycle_s[63:32];
         CSR_MINSTRET, CSR_INSTRET: old_s = minstret_s[31:0];
         CSR_MINSTRETH,CSR_INSTRETH:old_s = minstret_s[63:32];
         CSR_MHARTID:               old_s = HART_ID;
         default: begin
            old_s  = 32'd0;
            impl_s = 1'b0;
         end
      endcase
   end

   assign illegal_s = !impl_s || !csr_op_valid(op_q) || (we_q && (addr_q[11:10] == 2'b11));
   assign commit_s  = (state_q == ST_WRITE) && wen_q;

   // Sequencer next state and registered response values.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      we_d      = we_q;
      re_d      = re_q;
      addr_d    = addr_q;
      src_d     = src_q;
      new_d     = new_q;
      wen_d     = 1'b0;
      rdata_d   = 32'd0;
      ready_d   = 1'b0;
      illegal_d = 1'b0;
      busy_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (csr_valid) begin
               op_d    = CSRop;
               we_d    = CSRwe;
               re_d    = CSRre;
               addr_d  = csr_addr;
               src_d   = csr_op_is_imm(CSRop) ? {27'd0, uimm} : rs1_data;
               state_d = ST_READ;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            state_d   = ST_WRITE;
            busy_d    = 1'b1;
            ready_d   = 1'b1;
            illegal_d = illegal_s;
            rdata_d   = (re_q && !illegal_s) ? old_s : 32'd0;
            new_d     = csr_op_apply(op_q, old_s, src_q);
            wen_d     = we_q && !illegal_s;
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Commit of the new value under each CSR's write mask.
   always_comb begin
      mstatus_d   = mstatus_q;
      mie_d       = mie_q;
      mtvec_d     = mtvec_q;
      mscratch_d  = mscratch_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
      mtval_d     = mtval_q;
      mcy_wr_lo_s = 1'b0;
      mcy_wr_hi_s = 1'b0;
      mir_wr_lo_s = 1'b0;
      mir_wr_hi_s = 1'b0;
      if (commit_s) begin
         case (addr_q)
            CSR_MSTATUS:   mstatus_d   = new_q & MSTATUS_WMASK;
            CSR_MIE:       mie_d       = new_q & MIE_WMASK;
            CSR_MTVEC:     mtvec_d     = new_q & MTVEC_WMASK;
            CSR_MSCRATCH:  mscratch_d  = new_q;
            CSR_MEPC:      mepc_d      = new_q & MEPC_WMASK;
            CSR_MCAUSE:    mcause_d    = new_q;
            CSR_MTVAL:     mtval_d     = new_q;
            CSR_MCYCLE:    mcy_wr_lo_s = 1'b1;
            CSR_MCYCLEH:   mcy_wr_hi_s = 1'b1;
            CSR_MINSTRET:  mir_wr_lo_s = 1'b1;
            CSR_MINSTRETH: mir_wr_hi_s = 1'b1;
            default:       mstatus_d   = mstatus_q;
         endcase
      end else begin
         mstatus_d = mstatus_q;
      end
   end

   // State, request latch, response and CSR registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         addr_q     <= 12'd0;
         src_q      <= 32'd0;
         new_q      <= 32'd0;
         wen_q      <= 1'b0;
         rdata_q    <= 32'd0;
         ready_q    <= 1'b0;
         illegal_q  <= 1'b0;
         busy_q     <= 1'b0;
         mstatus_q  <= 32'd0;
         mie_q      <= 32'd0;
         mtvec_q    <= 32'd0;
         mscratch_q <= 32'd0;
         mepc_q     <= 32'd0;
         mcause_q   <= 32'd0;
         mtval_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         we_q       <= we_d;
         re_q       <= re_d;
         addr_q     <= addr_d;
         src_q      <= src_d;
         new_q      <= new_d;
         wen_q      <= wen_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         illegal_q  <= illegal_d;
         busy_q     <= busy_d;
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   assign csr_rdata   = rdata_q;
   assign csr_ready   = ready_q;
   assign csr_illegal = illegal_q;
   assign csr_busy    = busy_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: hand-computed expectations checked with
// immediate assertions at fixed cycle offsets from each request.
module tb_csr_exec_unit;
   import csr_exec_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        csr_valid;
   logic [2:0]  CSRop;
   logic        CSRwe, CSRre;
   logic [11:0] csr_addr;
   logic [31:0] rs1_data;
   logic [4:0]  uimm;
   logic        instret_inc;
   logic [31:0] csr_rdata;
   logic        csr_ready, csr_illegal, csr_busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   csr_exec_unit dut (
      .clk         (clk),
      .resetn      (resetn),
      .csr_valid   (csr_valid),
      .CSRop       (CSRop),
      .CSRwe       (CSRwe),
      .CSRre       (CSRre),
      .csr_addr    (csr_addr),
      .rs1_data    (rs1_data),
      .uimm        (uimm),
      .instret_inc (instret_inc),
      .csr_rdata   (csr_rdata),
      .csr_ready   (csr_ready),
      .csr_illegal (csr_illegal),
      .csr_busy    (csr_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full access starting on a negedge; returns on the negedge after WRITE.
   task automatic do_op(input logic [2:0] op, input logic we, input logic re,
                        input logic [11:0] addr, input logic [31:0] rs1, input logic [4:0] imm,
                        input logic [31:0] exp_rd, input logic exp_ill, input string tag);
      csr_valid = 1'b1;
      CSRop     = op;
      CSRwe     = we;
      CSRre     = re;
      csr_addr  = addr;
      rs1_data  = rs1;
      uimm      = imm;
      @(posedge clk);
      @(negedge clk);
      csr_valid = 1'b0;
      rs1_data  = 32'hCAFE_F00D;
      uimm      = 5'h1A;
      chk($sformatf("%s.ready_read", tag), {31'd0, csr_ready}, 32'd0);
      chk($sformatf("%s.busy_read", tag), {31'd0, csr_busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s.ready", tag), {31'd0, csr_ready}, 32'd1);
      chk($sformatf("%s.rdata", tag), csr_rdata, exp_rd);
      chk($sformatf("%s.illegal", tag), {31'd0, csr_illegal}, {31'd0, exp_ill});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s.ready_after", tag), {31'd0, csr_ready}, 32'd0);
      chk($sformatf("%s.busy_after", tag), {31'd0, csr_busy}, 32'd0);
   endtask

   initial begin
      resetn      = 1'b0;
      csr_valid   = 1'b0;
      CSRop       = CSR_OP_NA;
      CSRwe       = 1'b0;
      CSRre       = 1'b0;
      csr_addr    = 12'd0;
      rs1_data    = 32'd0;
      uimm        = 5'd0;
      instret_inc = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.rdata", csr_rdata, 32'd0);
      chk("reset.ready", {31'd0, csr_ready}, 32'd0);
      chk("reset.illegal", {31'd0, csr_illegal}, 32'd0);
      chk("reset.busy", {31'd0, csr_busy}, 32'd0);
      resetn = 1'b1;

      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MSCRATCH, 32'hDEAD_BEEF, 5'd0, 32'h0000_0000, 1'b0, "mscratch_rw");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSCRATCH, 32'h0000_0000, 5'd0, 32'hDEAD_BEEF, 1'b0, "mscratch_rd");
      do_op(CSR_OP_RSI, 1'b1, 1'b1, CSR_MSTATUS,  32'h0000_0000, 5'd8, 32'h0000_1800, 1'b0, "mstatus_rsi");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSTATUS,  32'h0000_0000, 5'd0, 32'h0000_1808, 1'b0, "mstatus_rd1");
      do_op(CSR_OP_RCI, 1'b1, 1'b1, CSR_MSTATUS,  32'h0000_0000, 5'd8, 32'h0000_1808, 1'b0, "mstatus_rci");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSTATUS,  32'h0000_0000, 5'd0, 32'h0000_1800, 1'b0, "mstatus_rd2");
      do_op(CSR_OP_RS,  1'b1, 1'b1, CSR_MSTATUS,  32'hFFFF_FFFF, 5'd0, 32'h0000_1800, 1'b0, "mstatus_setall");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSTATUS,  32'h0000_0000, 5'd0, 32'h0000_1888, 1'b0, "mstatus_rd3");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MTVEC,    32'h8000_0003, 5'd0, 32'h0000_0000, 1'b0, "mtvec_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MTVEC,    32'h0000_0000, 5'd0, 32'h8000_0000, 1'b0, "mtvec_rd");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MEPC,     32'h0000_1237, 5'd0, 32'h0000_0000, 1'b0, "mepc_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MEPC,     32'h0000_0000, 5'd0, 32'h0000_1234, 1'b0, "mepc_rd");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MIE,      32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0, "mie_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MIE,      32'h0000_0000, 5'd0, 32'h0000_0888, 1'b0, "mie_rd");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MISA,     32'h0000_0000, 5'd0, 32'h4000_1101, 1'b0, "misa_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MISA,     32'h0000_0000, 5'd0, 32'h4000_1101, 1'b0, "misa_rd");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MCAUSE,   32'hA5A5_A5A5, 5'd0, 32'h0000_0000, 1'b0, "mcause_wr");
      do_op(CSR_OP_RC,  1'b1, 1'b1, CSR_MCAUSE,   32'h0000_FFFF, 5'd0, 32'hA5A5_A5A5, 1'b0, "mcause_rc");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MCAUSE,   32'h0000_0000, 5'd0, 32'hA5A5_0000, 1'b0, "mcause_rd");
      do_op(CSR_OP_RW,  1'b1, 1'b0, CSR_MTVAL,    32'h1234_5678, 5'd0, 32'h0000_0000, 1'b0, "mtval_wr_nore");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MTVAL,    32'h0000_0000, 5'd0, 32'h1234_5678, 1'b0, "mtval_rd");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MHARTID,  32'h0000_0000, 5'd0, 32'h0000_0000, 1'b0, "mhartid_rd");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MHARTID,  32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, "mhartid_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, 12'h7C0,      32'h0000_0000, 5'd0, 32'h0000_0000, 1'b1, "unimpl_rd");
      do_op(CSR_OP_NA,  1'b0, 1'b1, CSR_MSCRATCH, 32'h0000_0000, 5'd0, 32'h0000_0000, 1'b1, "op_na");
      do_op(CSR_OP_RWI, 1'b1, 1'b1, CSR_MSCRATCH, 32'h0000_0000, 5'h1F, 32'hDEAD_BEEF, 1'b0, "mscratch_rwi");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSCRATCH, 32'h0000_0000, 5'd0, 32'h0000_001F, 1'b0, "mscratch_rd2");

      // Back-to-back from here: each access is exactly three cycles apart.
      do_op(CSR_OP_RW,  1'b1, 1'b0, CSR_MCYCLEH,  32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0, "mcycleh_wr");
      do_op(CSR_OP_RW,  1'b1, 1'b0, CSR_MCYCLE,   32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0, "mcycle_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MCYCLE,   32'h0000_0000, 5'd0, 32'h0000_0000, 1'b0, "mcycle_wrap_lo");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MCYCLEH,  32'h0000_0000, 5'd0, 32'h0000_0000, 1'b0, "mcycle_wrap_hi");
      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_CYCLE,    32'h1234_5678, 5'd0, 32'h0000_0000, 1'b1, "cycle_wr");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_CYCLE,    32'h0000_0000, 5'd0, 32'h0000_0009, 1'b0, "cycle_rd");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_CYCLEH,   32'h0000_0000, 5'd0, 32'h0000_0000, 1'b0, "cycleh_rd");

      do_op(CSR_OP_RW,  1'b1, 1'b1, CSR_MINSTRET, 32'h0000_0010, 5'd0, 32'h0000_0000, 1'b0, "minstret_wr");
      instret_inc = 1'b1;
      @(negedge clk);
      instret_inc = 1'b0;
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_INSTRET,  32'h0000_0000, 5'd0, 32'h0000_0011, 1'b0, "instret_rd");

      // Reset pulse while the access sits in READ.
      csr_valid = 1'b1;
      CSRop     = CSR_OP_RW;
      CSRwe     = 1'b1;
      CSRre     = 1'b1;
      csr_addr  = CSR_MSCRATCH;
      rs1_data  = 32'h5555_5555;
      @(posedge clk);
      @(negedge clk);
      csr_valid = 1'b0;
      chk("rst_mid.busy_read", {31'd0, csr_busy}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("rst_mid.busy", {31'd0, csr_busy}, 32'd0);
      chk("rst_mid.ready", {31'd0, csr_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid.ready2", {31'd0, csr_ready}, 32'd0);
      resetn = 1'b1;
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSCRATCH, 32'h0000_0000, 5'd0, 32'h0000_0000, 1'b0, "post_rst_mscratch");
      do_op(CSR_OP_RS,  1'b0, 1'b1, CSR_MSTATUS,  32'h0000_0000, 5'd0, 32'h0000_1800, 1'b0, "post_rst_mstatus");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
